pipe_decoder: RTL and testbench

PIPE_DECODER -- requirements
Module: pipe_decoder

---
 rtl/pipe_decoder_pkg.sv | 13 +
 rtl/pipe_decoder_stage.sv | 91 +++++++++
 rtl/pipe_decoder.sv | 94 +++++++++
 tb/tb_pipe_decoder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_decoder_pkg.sv
// Shared types and constants for the pipelined
// binary-to-one-hot/thermometer decoder.
package pipe_decoder_pkg;

  typedef enum logic {
    MODE_ONEHOT = 1'b0,
    MODE_THERM  = 1'b1
  } mode_e;

  localparam int MAX_IN_W = 12;
  localparam int CNT_W    = 16;

endpackage

// File: rtl/pipe_decoder_stage.sv
// One register stage: consumes NB select bits (MSB first)
// and expands the equal/less-than partial words.
module pipe_decoder_stage
  import pipe_decoder_pkg::*;
#(
  parameter int IN_W = 10,
  parameter int DONE = 0,
  parameter int NB   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [IN_W-1:0]   up_sel,
  input  logic              up_en,
  input  mode_e             up_mode,
  input  logic [(1<<IN_W)-1:0] up_oh,
  input  logic [(1<<IN_W)-1:0] up_lt,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [IN_W-1:0]   dn_sel,
  output logic              dn_en,
  output mode_e             dn_mode,
  output logic [(1<<IN_W)-1:0] dn_oh,
  output logic [(1<<IN_W)-1:0] dn_lt
);

  localparam int W = 1 << IN_W;

  logic         load;
  logic         b;
  logic [W-1:0] oh;
  logic [W-1:0] lt;
  logic [W-1:0] noh;
  logic [W-1:0] nlt;
  logic         unused_hi;

  // Only the low half of the partial words can be live
  // before this stage's expansion.
  assign unused_hi = ^{up_oh[W-1:W/2], up_lt[W-1:W/2]};

  assign up_ready = !dn_valid || dn_ready;
  assign load     = up_valid && up_ready;

  // Each bit doubles the partial word: entry i splits
  // into 2i (bit=0) and 2i+1 (bit=1).
  always_comb begin
    oh  = up_oh;
    lt  = up_lt;
    noh = '0;
    nlt = '0;
    b   = 1'b0;
    for (int s = 0; s < NB; s++) begin
      b   = up_sel[IN_W-1-DONE-s];
      noh = '0;
      nlt = '0;
      for (int i = 0; i < W / 2; i++) begin
        if (i < (1 << (DONE + s))) begin
          noh[2*i]   = oh[i] & ~b;
          noh[2*i+1] = oh[i] & b;
          nlt[2*i]   = lt[i] | (oh[i] & b);
          nlt[2*i+1] = lt[i];
        end
      end
      oh = noh;
      lt = nlt;
    end
  end

  // Valid/ready slice with full-throughput advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_sel   <= '0;
      dn_en    <= 1'b0;
      dn_mode  <= MODE_ONEHOT;
      dn_oh    <= '0;
      dn_lt    <= '0;
    end else if (load) begin
      dn_valid <= 1'b1;
      dn_sel   <= up_sel;
      dn_en    <= up_en;
      dn_mode  <= up_mode;
      dn_oh    <= oh;
      dn_lt    <= lt;
    end else if (dn_ready) begin
      dn_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_decoder.sv
// Pipelined one-hot/thermometer decoder, STAGES deep.
// Optional handoff counter: PIPE_DECODER_CNT_EN.
module pipe_decoder
  import pipe_decoder_pkg::*;
#(
  parameter int IN_W   = 10,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_sel,
  input  logic                 in_en,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [(1<<IN_W)-1:0] out_dec
`ifdef PIPE_DECODER_CNT_EN
  ,
  output logic [CNT_W-1:0]     out_cnt
`endif
);

  localparam int W = 1 << IN_W;

  logic            vld  [STAGES+1];
  logic            rdy  [STAGES+1];
  logic [IN_W-1:0] sel  [STAGES+1];
  logic            en   [STAGES+1];
  mode_e           mode [STAGES+1];
  logic [W-1:0]    oh   [STAGES+1];
  logic [W-1:0]    lt   [STAGES+1];
  logic            unused_sel;

  assign vld[0]      = in_valid;
  assign sel[0]      = in_sel;
  assign en[0]       = in_en;
  assign mode[0]     = mode_e'(in_mode);
  assign oh[0]       = W'(1);
  assign lt[0]       = '0;
  assign rdy[STAGES] = out_ready;

  assign in_ready   = rst_n && rdy[0];
  assign out_valid  = vld[STAGES];
  assign unused_sel = ^sel[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    pipe_decoder_stage #(
      .IN_W (IN_W),
      .DONE (k * IN_W / STAGES),
      .NB   ((k + 1) * IN_W / STAGES - k * IN_W / STAGES)
    ) u_st (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (vld[k]),
      .up_ready (rdy[k]),
      .up_sel   (sel[k]),
      .up_en    (en[k]),
      .up_mode  (mode[k]),
      .up_oh    (oh[k]),
      .up_lt    (lt[k]),
      .dn_valid (vld[k+1]),
      .dn_ready (rdy[k+1]),
      .dn_sel   (sel[k+1]),
      .dn_en    (en[k+1]),
      .dn_mode  (mode[k+1]),
      .dn_oh    (oh[k+1]),
      .dn_lt    (lt[k+1])
    );
  end

  // Thermometer is "less than" or "equal"; disable zeroes it.
  always_comb begin
    out_dec = '0;
    if (en[STAGES]) begin
      if (mode[STAGES] == MODE_THERM)
        out_dec = oh[STAGES] | lt[STAGES];
      else
        out_dec = oh[STAGES];
    end
  end

`ifdef PIPE_DECODER_CNT_EN
  // Wrapping count of output handoffs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_cnt <= '0;
    else if (out_valid && out_ready)
      out_cnt <= out_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pipe_decoder.sv
// Randomized scoreboard bench for pipe_decoder
// (IN_W=10, STAGES=2), plus directed corner cases.
module tb_pipe_decoder;

  localparam int IN_W   = 10;
  localparam int STAGES = 2;
  localparam int W      = 1 << IN_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_sel;
  logic            in_en;
  logic            in_mode;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_dec;
`ifdef PIPE_DECODER_CNT_EN
  logic [15:0]     out_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic [W-1:0] q[$];
  bit held = 0;
  logic [W-1:0] held_dec;

  pipe_decoder #(.IN_W(IN_W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_en     (in_en),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dec   (out_dec)
`ifdef PIPE_DECODER_CNT_EN
    ,
    .out_cnt   (out_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    int c;
    checks++;
    if (got !== exp) begin
      errors++;
      c = 0;
      for (int k = 0; k < W / 64; k++)
        if (got[k*64 +: 64] !== exp[k*64 +: 64]) begin
          c = k;
          break;
        end
      $display("FAIL %s chunk%0d got=%h exp=%h",
               tag, c, got[c*64 +: 64], exp[c*64 +: 64]);
    end
  endtask

  function automatic logic [W-1:0] model(int s, bit e, bit m);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++)
      r[i] = e && (m ? (i <= s) : (i == s));
    return r;
  endfunction

  // Scoreboard: samples handshakes mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      held = 0;
      chk("rst_ready", in_ready, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_dec", out_dec, 0);
    end else begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_dec", out_dec, held_dec);
      end
      chk("in_ready", in_ready,
          (q.size() < STAGES) || out_ready);
      if (out_valid && out_ready) begin
        delivered++;
        chk("underflow", q.size() != 0, 1);
        if (q.size() != 0)
          chk("order", out_dec, q.pop_front());
      end
      if (in_valid && in_ready)
        q.push_back(model(int'(in_sel), in_en, in_mode));
      held = out_valid && !out_ready;
      held_dec = out_dec;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Send one word into an empty pipe; check exact latency.
  task automatic xfer(input string tag, input int s,
                      input bit e, input bit m);
    out_ready = 1;
    in_valid  = 1;
    in_sel    = IN_W'(s);
    in_en     = e;
    in_mode   = m;
    cyc();
    in_valid = 0;
    for (int k = 1; k < STAGES; k++) begin
      chk({tag, "_early"}, out_valid, 0);
      cyc();
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, out_dec, model(s, e, m));
    cyc();
  endtask

  task automatic do_reset();
    rst_n = 0;
    in_valid = 0;
    repeat (2) cyc();
    rst_n = 1;
  endtask

  initial begin
    int sent, base, n;
    rst_n = 0;
    in_valid = 0;
    in_sel = '0;
    in_en = 0;
    in_mode = 0;
    out_ready = 0;
    repeat (3) cyc();
    chk("reset_dec", out_dec, 0);
`ifdef PIPE_DECODER_CNT_EN
    chk("reset_cnt", out_cnt, 0);
`endif
    rst_n = 1;
    #1;
    chk("first_ready", in_ready, 1);

    xfer("onehot5", 5, 1, 0);
    xfer("therm3", 3, 1, 1);
    xfer("therm1023", 1023, 1, 1);
    xfer("onehot1023", 1023, 1, 0);
    xfer("onehot0", 0, 1, 0);
    xfer("dis_oh7", 7, 0, 0);
    xfer("dis_th7", 7, 0, 1);

    // Backpressure: words 0..3, stalled 5 cycles.
    base = delivered;
    sent = 0;
    out_ready = 0;
    in_valid = 1;
    in_en = 1;
    in_mode = 0;
    in_sel = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n = int'(in_valid && in_ready);
      cyc();
      if (n != 0) begin
        sent++;
        in_sel = IN_W'(sent);
      end
    end
    chk("bp_sent", sent, STAGES);
    chk("bp_ready", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_word0", out_dec, model(0, 1, 0));
    out_ready = 1;
    for (int c = 0; c < 50 && sent < 4; c++) begin
      @(negedge clk);
      n = int'(in_valid && in_ready);
      cyc();
      if (n != 0) begin
        sent++;
        in_sel = IN_W'(sent);
      end
    end
    in_valid = 0;
    repeat (STAGES + 2) cyc();
    chk("bp_delivered", delivered - base, 4);

    // Reset with two words in flight.
    out_ready = 0;
    in_valid = 1;
    in_sel = 10'd9;
    repeat (3) cyc();
    in_valid = 0;
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 0;
    #1;
    chk("rst_now_valid", out_valid, 0);
    chk("rst_now_dec", out_dec, 0);
`ifdef PIPE_DECODER_CNT_EN
    chk("rst_now_cnt", out_cnt, 0);
`endif
    cyc();
    rst_n = 1;
    out_ready = 1;
    base = delivered;
    repeat (6) cyc();
    chk("no_stale", delivered - base, 0);
    chk("no_stale_valid", out_valid, 0);

    // Random traffic against the scoreboard.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      in_sel    = ($urandom_range(0, 7) == 0) ?
                  10'd1023 : IN_W'($urandom);
      in_en     = $urandom_range(0, 7) != 0;
      in_mode   = 1'($urandom);
      cyc();
    end
    in_valid = 0;
    out_ready = 1;
    repeat (STAGES + 3) cyc();
    chk("drain", q.size(), 0);

`ifdef PIPE_DECODER_CNT_EN
    do_reset();
    chk("cnt_zero", out_cnt, 0);
    base = delivered;
    sent = 0;
    out_ready = 1;
    in_valid = 1;
    in_en = 1;
    in_mode = 0;
    for (int c = 0; c < 70000 && sent < 65537; c++) begin
      in_sel = IN_W'($urandom);
      @(negedge clk);
      n = int'(in_valid && in_ready);
      cyc();
      if (n != 0)
        sent++;
      if (sent == 65537)
        in_valid = 0;
    end
    in_valid = 0;
    repeat (STAGES + 3) cyc();
    chk("cnt_handoffs", delivered - base, 65537);
    chk("cnt_wrap", out_cnt, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
